// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit signed subtractor with borrow-in, LSB first:
//     D = (A - B - b_in) mod 2^N, one bit per clock.
//   A transaction takes N+2 cycles (accept, N RUN edges, hand-off) and
//   needs one full adder cell plus shift registers.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. in_ready is high only in IDLE, and
//   out_valid is high only in DONE. The source must hold A/B/b_in stable
//   with in_valid high until the transfer. D/b_out/ovf do not change while
//   out_valid is high.
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   in_valid   A, B, b_in are valid
//   in_ready   block can accept operands (IDLE)
//   A, B       signed minuend / subtrahend, N bits
//   b_in       borrow-in, weight +1
//   out_valid  D, b_out, ovf are valid (DONE)
//   out_ready  consumer accepts the result
//   D          difference, N bits
//   b_out      unsigned borrow-out
//   ovf        signed overflow
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] D,
  output logic         b_out,
  output logic         ovf,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [N-1:0]  a_sh, b_sh;
  logic [N-2:0]  d_sh;      // result bits produced so far, MSB-aligned
  logic [CW-1:0] cnt;
  logic          br;

  logic          bit_a, bit_b, bit_d, br_next, last_bit;
  logic [N-1:0]  d_full;

  // One full-subtractor cell working on the current LSBs.
  always_comb begin
    bit_a    = a_sh[0];
    bit_b    = b_sh[0];
    bit_d    = bit_a ^ bit_b ^ br;
    br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
    last_bit = (cnt == CW'(N - 1));
    d_full   = {bit_d, d_sh};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbg_state = state;

  // Datapath. D/b_out/ovf are only written on the last RUN edge, so they
  // hold through DONE and keep their value after the hand-off.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      D     <= '0;
      b_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= A;
            b_sh <= B;
            br   <= b_in;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_full[N-1:1];
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            D     <= d_full;
            b_out <= br_next;
            // On the last bit, bit_a/bit_b are the operand sign bits and
            // bit_d is the result sign bit.
            ovf   <= (bit_a ^ bit_b) & (bit_d ^ bit_a);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed vectors with hand-computed results for serial_subtractor (N=8),
//   a reset-during-RUN case, and a random streaming run checked against an
//   expected queue filled from a widened arithmetic model.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a_in, b_in_op;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] d;
  logic         b_out;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];

  serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in_op),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d),
    .b_out     (b_out),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: widen to N+1 bits so bit N is the borrow-out.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic bin);
    logic [8:0] diff;
    logic       ov;
    diff = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    ov   = (a[7] != b[7]) && (diff[7] != a[7]);
    return {ov, diff[8], diff[7:0]};
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_ready(input string tag);
    int i;
    for (i = 0; i < 50 && !in_ready; i++) step();
    check({tag, "_ready"}, in_ready, 1'b1);
  endtask

  // Issue one operation, check latency, result, optional hold, and hand-off.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] exp_d, input logic exp_bo,
                       input logic exp_ov, input int hold);
    int bad;
    wait_ready(tag);
    a_in = a; b_in_op = b; b_in = bin; in_valid = 1'b1;
    step();                               // accepting edge
    in_valid = 1'b0;
    a_in = 8'h5A; b_in_op = 8'hC3; b_in = 1'b1;  // operands already latched
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      step();
    end
    check({tag, "_busy"}, bad, 0);
    check({tag, "_latency"}, out_valid, 1'b1);
    check({tag, "_result"}, {ovf, b_out, d}, {exp_ov, exp_bo, exp_d});
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = h[0];                   // pulses while busy must be ignored
      step();
      check({tag, "_hold"}, {out_valid, in_ready, ovf, b_out, d},
            {1'b1, 1'b0, exp_ov, exp_bo, exp_d});
    end
    in_valid  = (hold > 0);               // no accept on the hand-off edge
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_handoff"}, {out_valid, in_ready, dbg_state}, {1'b0, 1'b1, 2'd0});
    in_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_tx, n_rx;
    bit pend;
    logic [9:0] got;

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in_op = '0; b_in = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    check("reset_state", {in_ready, out_valid, ovf, b_out, d, dbg_state},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0});

    // Directed vectors.
    do_op("sub_15_10",   8'd15,  8'd10,  1'b0, 8'h05, 1'b0, 1'b0, 0);
    do_op("sub_5_10",    8'd5,   8'd10,  1'b0, 8'hFB, 1'b1, 1'b0, 0);
    do_op("sub_m128_1",  8'h80,  8'h01,  1'b0, 8'h7F, 1'b0, 1'b1, 0);
    do_op("sub_127_m1",  8'h7F,  8'hFF,  1'b0, 8'h80, 1'b1, 1'b1, 0);
    do_op("sub_80_80_1", 8'h80,  8'h80,  1'b1, 8'hFF, 1'b1, 1'b0, 0);
    do_op("sub_ff_0_1",  8'hFF,  8'h00,  1'b1, 8'hFE, 1'b0, 1'b0, 0);
    do_op("sub_0_0_1",   8'h00,  8'h00,  1'b1, 8'hFF, 1'b1, 1'b0, 5);

    // Reset in the middle of RUN drops the operation.
    wait_ready("rst_mid");
    a_in = 8'd50; b_in_op = 8'd20; b_in = 1'b0; in_valid = 1'b1;
    step();                               // accept
    in_valid = 1'b0;
    step();                               // RUN edge 1
    step();                               // RUN edge 2
    rstn = 1'b0; in_valid = 1'b1;
    step();                               // RUN edge 3, reset
    check("rst_mid_state", {out_valid, in_ready, ovf, b_out, d, dbg_state},
          {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0});
    step();                               // reset with in_valid high in IDLE
    check("rst_no_accept", {in_ready, dbg_state}, {1'b1, 2'd0});
    rstn = 1'b1; in_valid = 1'b0;
    do_op("sub_20_7",    8'd20,  8'd7,   1'b0, 8'h0D, 1'b0, 1'b0, 0);

    // Random stream with random in_valid gaps and out_ready backpressure.
    n_tx = 0; n_rx = 0; pend = 0;
    for (int cyc = 0; cyc < 20000 && n_rx < 200; cyc++) begin
      step();
      if (pend) begin
        in_valid = 1'b0;
        pend = 0;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        got = {ovf, b_out, d};
        if (exp_q.size() == 0) check("rand_unexpected", 1, 0);
        else check("rand_result", got, exp_q.pop_front());
        n_rx++;
      end
      if (!in_valid && n_tx < 200 && $urandom_range(0, 3) != 0) begin
        a_in     = 8'($urandom_range(0, 255));
        b_in_op  = 8'($urandom_range(0, 255));
        b_in     = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a_in, b_in_op, b_in));
        n_tx++;
        pend = 1;
      end
    end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("rand_sent", n_tx, 200);
    check("rand_received", n_rx, 200);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit signed subtractor with borrow-in. Computes D = A - B - b_in, one bit per clock, LSB first.
- Inverse-direction companion to the team's combinational n_adder. Shares its operand conventions: signed N-bit A/B, 1-bit carry/borrow in/out.
- Valid/ready handshakes on input and output let it sit in streaming datapaths where area matters more than latency.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset.
- in_valid  input  1  operands A, B, b_in valid.
- in_ready  output  1  block can accept operands.
- A  input  N  signed minuend.
- B  input  N  signed subtrahend.
- b_in  input  1  borrow-in, subtracted as +1 weight.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- D  output  N  signed difference, (A - B - b_in) mod 2^N.
- b_out  output  1  unsigned borrow-out.
- ovf  output  1  signed overflow flag.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-low: rstn sampled low on a rising clk edge resets the block.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, D=0, b_out=0, ovf=0, bit counter=0, borrow register=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On the edge where in_valid&&in_ready: latch A, B into shift registers; load borrow register with b_in; clear counter; go to RUN.
  - RUN: in_ready=0, out_valid=0.
    - Each edge processes bit i = counter, with a = A_sh[0], b = B_sh[0], br = borrow register:
      - d = a^b^br
      - br_next = (~a&b) | (~(a^b)&br)
    - d shifts into the MSB of the result register, which shifts right. Counter increments.
    - On the edge processing bit N-1: capture ovf, take b_out = br_next, go to DONE.
  - DONE: out_valid=1, in_ready=0.
    - D, b_out, ovf held stable while out_ready=0.
    - On the edge where out_ready=1: go to IDLE; out_valid=0 from the next cycle.
    - No operand is accepted on that same edge.
- Latency and throughput:
  - out_valid rises exactly N edges after the accepting edge.
  - Minimum issue interval is N+2 cycles with out_ready tied high.
- Arithmetic rules:
  - D = (A - B - b_in) mod 2^N.
  - b_out = 1 iff unsigned(A) < unsigned(B) + b_in.
  - Invariant: unsigned(A) - unsigned(B) - b_in == unsigned(D) - b_out*2^N.
  - ovf = (A[N-1] != B[N-1]) && (D[N-1] != A[N-1]), computed from the latched A/B sign bits. b_in does not enter this term.
- Boundary conditions:
  - in_valid asserted while busy (RUN/DONE): ignored, not queued. The source must hold its operands until in_ready.
  - Input operand changes during RUN: no effect, because operands are latched.
  - D/b_out/ovf after a transfer: retain their last values until the next DONE; they are only meaningful while out_valid=1.
  - rstn low in any state, including mid-RUN or in DONE with backpressure: the in-flight operation is dropped; reset values apply after that edge.
  - rstn low with in_valid=1: no accept on that edge.

Test Plan (N=8):
- 15 - 10 - 0 -> D=5, b_out=0, ovf=0. out_valid rises exactly 8 edges after accept; in_ready=0 throughout.
- 5 - 10 - 0 -> D=-5 (0xFB), b_out=1, ovf=0.
- -128 - 1 - 0 -> D=127 (0x7F), b_out=0, ovf=1. Also 127 - (-1) - 0 -> D=-128 (0x80), b_out=1, ovf=1.
- 0 - 0 - 1 with out_ready held low 5 cycles after out_valid -> D=0xFF, b_out=1, ovf=0, all held stable. in_valid pulses during the hold are ignored. Transfer completes on the first out_ready=1 edge; in_ready=1 one cycle later.
- Accept 50 - 20, drive rstn low at the 3rd RUN edge -> next cycle out_valid=0, in_ready=1, D=0. Then 20 - 7 - 0 -> D=13, b_out=0.
- 200 random back-to-back operations with random in_valid/out_ready -> every result satisfies the invariant and the ovf equation; no operand is lost or duplicated (scoreboard order check).
